// File: rtl/uart_apb_bridge.sv
// APB3 slave bridging 32-bit bus transfers onto the UART 8-bit strobe register
// port, with address-error responses and a masked, registered interrupt merge.
module uart_apb_bridge #(
  parameter logic [15:0] UART_LAST     = 16'h0020,
  parameter logic [15:0] IRQ_EN_ADDR   = 16'h0040,
  parameter logic [15:0] IRQ_STAT_ADDR = 16'h0044
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        psel,
  input  logic        penable,
  input  logic        pwrite,
  input  logic [31:0] paddr,
  input  logic [31:0] pwdata,
  output logic [31:0] prdata,
  output logic        pready,
  output logic        pslverr,
  output logic [15:0] reg_addr,
  output logic        reg_cs_n,
  output logic        reg_wr_n,
  output logic        reg_rd_n,
  output logic [7:0]  reg_wdata,
  input  logic [7:0]  reg_rdata,
  input  logic        ri,
  input  logic        ti,
  output logic        irq
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_STROBE  = 2'd1;
  localparam logic [1:0] S_CAPTURE = 2'd2;
  localparam logic [1:0] S_RESP    = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        write_q, write_d;
  logic        err_q, err_d;
  logic        local_q, local_d;
  logic        cs_n_q, cs_n_d;
  logic        wr_n_q, wr_n_d;
  logic        rd_n_q, rd_n_d;
  logic [7:0]  rdata_q, rdata_d;
  logic [1:0]  irq_en_q, irq_en_d;
  logic        irq_q, irq_d;

  logic        setup;
  logic        dec_local;
  logic        dec_err;
  logic        unused_bits;

  assign unused_bits = ^{paddr[31:16], pwdata[31:8]};

  assign setup     = psel & ~penable;
  assign dec_local = (paddr[15:0] == IRQ_EN_ADDR) || (paddr[15:0] == IRQ_STAT_ADDR);
  assign dec_err   = (paddr[1:0] != 2'b00) || ((paddr[15:0] > UART_LAST) && !dec_local);

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    write_d  = write_q;
    err_d    = err_q;
    local_d  = local_q;
    irq_en_d = irq_en_q;
    cs_n_d   = 1'b1;
    wr_n_d   = 1'b1;
    rd_n_d   = 1'b1;
    rdata_d  = 8'h00;
    irq_d    = |({ti, ri} & irq_en_q);
    case (state_q)
      S_IDLE: begin
        if (setup) begin
          addr_d  = paddr[15:0];
          wdata_d = pwdata[7:0];
          write_d = pwrite;
          err_d   = dec_err;
          local_d = dec_local & ~dec_err;
          state_d = dec_err ? S_RESP : S_STROBE;
          // Strobes are registered, so they are launched here to be low in STROBE.
          if (!dec_err && !dec_local) begin
            cs_n_d = 1'b0;
            wr_n_d = ~pwrite;
            rd_n_d = pwrite;
          end
        end
      end
      S_STROBE: begin
        if (local_q && write_q && (addr_q == IRQ_EN_ADDR)) begin
          irq_en_d = wdata_q[1:0];
        end
        state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        if (!write_q) begin
          if (!local_q) begin
            rdata_d = reg_rdata;
          end else if (addr_q == IRQ_EN_ADDR) begin
            rdata_d = {6'b0, irq_en_q};
          end else begin
            rdata_d = {6'b0, ti, ri};
          end
        end
        state_d = S_RESP;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      addr_q   <= 16'h0000;
      wdata_q  <= 8'h00;
      write_q  <= 1'b0;
      err_q    <= 1'b0;
      local_q  <= 1'b0;
      cs_n_q   <= 1'b1;
      wr_n_q   <= 1'b1;
      rd_n_q   <= 1'b1;
      rdata_q  <= 8'h00;
      irq_en_q <= 2'b00;
      irq_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      write_q  <= write_d;
      err_q    <= err_d;
      local_q  <= local_d;
      cs_n_q   <= cs_n_d;
      wr_n_q   <= wr_n_d;
      rd_n_q   <= rd_n_d;
      rdata_q  <= rdata_d;
      irq_en_q <= irq_en_d;
      irq_q    <= irq_d;
    end
  end

  assign pready    = (state_q == S_RESP);
  assign pslverr   = pready & err_q;
  assign prdata    = {24'h000000, rdata_q};
  assign reg_addr  = addr_q;
  assign reg_wdata = wdata_q;
  assign reg_cs_n  = cs_n_q;
  assign reg_wr_n  = wr_n_q;
  assign reg_rd_n  = rd_n_q;
  assign irq       = irq_q;

endmodule

// File: tb/tb_uart_apb_bridge.sv
// Randomized scoreboard bench for uart_apb_bridge with a transaction-level
// reference model and a small UART register-file model on the strobe port.
module tb_uart_apb_bridge;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        psel = 1'b0;
  logic        penable = 1'b0;
  logic        pwrite = 1'b0;
  logic [31:0] paddr = 32'h0;
  logic [31:0] pwdata = 32'h0;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;
  logic [15:0] reg_addr;
  logic        reg_cs_n;
  logic        reg_wr_n;
  logic        reg_rd_n;
  logic [7:0]  reg_wdata;
  logic [7:0]  reg_rdata;
  logic        ri = 1'b0;
  logic        ti = 1'b0;
  logic        irq;

  uart_apb_bridge dut (
    .clk(clk), .reset_n(reset_n), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr),
    .reg_addr(reg_addr), .reg_cs_n(reg_cs_n), .reg_wr_n(reg_wr_n), .reg_rd_n(reg_rd_n),
    .reg_wdata(reg_wdata), .reg_rdata(reg_rdata), .ri(ri), .ti(ti), .irq(irq)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  typedef struct packed {logic [31:0] data; logic err;} rsp_t;
  typedef struct packed {logic wr; logic [15:0] addr; logic [7:0] wdata;} stb_t;
  rsp_t rsp_q[$];
  stb_t stb_q[$];

  // Reference model state
  logic [7:0] ref_mem [0:15];
  logic [1:0] ref_en;

  // UART register file: read data appears one cycle after the read strobe
  logic [7:0] uart_mem [0:15];
  logic [7:0] uart_rd = 8'h00;
  logic       tb_load = 1'b0;
  always @(posedge clk) begin
    if (tb_load) begin
      for (int i = 0; i < 16; i++) uart_mem[i] <= ref_mem[i];
    end else if (!reg_cs_n && !reg_wr_n) begin
      uart_mem[reg_addr[5:2]] <= reg_wdata;
    end
    if (!reg_cs_n && !reg_rd_n) uart_rd <= uart_mem[reg_addr[5:2]];
  end
  assign reg_rdata = uart_rd;

  // Response monitor
  always @(negedge clk) begin
    rsp_t e;
    if (pready) begin
      if (rsp_q.size() == 0) begin
        check("unexpected_pready", 32'd1, 32'd0);
      end else begin
        e = rsp_q.pop_front();
        check("prdata", prdata, e.data);
        check("pslverr", {31'b0, pslverr}, {31'b0, e.err});
      end
    end
  end

  // Strobe monitor: content, direction and isolation between pulses
  int cyc = 0;
  int last_stb = -100;
  always @(negedge clk) begin
    stb_t s;
    cyc++;
    if (!reg_cs_n) begin
      check("strobe_gap", {31'b0, (cyc - last_stb) >= 4}, 32'd1);
      last_stb = cyc;
      if (stb_q.size() == 0) begin
        check("unexpected_strobe", 32'd1, 32'd0);
      end else begin
        s = stb_q.pop_front();
        check("strobe_wr_n", {31'b0, reg_wr_n}, {31'b0, ~s.wr});
        check("strobe_rd_n", {31'b0, reg_rd_n}, {31'b0, s.wr});
        check("strobe_addr", {16'b0, reg_addr}, {16'b0, s.addr});
        if (s.wr) check("strobe_wdata", {24'b0, reg_wdata}, {24'b0, s.wdata});
      end
    end else if (reg_wr_n !== 1'b1 || reg_rd_n !== 1'b1) begin
      check("stray_strobe", {30'b0, reg_wr_n, reg_rd_n}, 32'd3);
    end
  end

  task automatic apb(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                     input int exp_waits);
    int waits;
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data;
    @(negedge clk);
    penable = 1'b1;
    waits = 0;
    while (!pready && waits < 10) begin
      @(negedge clk);
      waits++;
    end
    check("wait_states", waits, exp_waits);
  endtask

  // Classify from the address rules, queue the expected outcome, then run it
  task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] data);
    logic [15:0] off;
    rsp_t r;
    stb_t s;
    off = addr[15:0];
    if (off[1:0] != 2'b00 || (off > 16'h20 && off != 16'h40 && off != 16'h44)) begin
      r.data = 32'h0; r.err = 1'b1;
      rsp_q.push_back(r);
      apb(wr, addr, data, 0);
    end else if (off == 16'h40 || off == 16'h44) begin
      r.err = 1'b0;
      r.data = 32'h0;
      if (wr && off == 16'h40) ref_en = data[1:0];
      if (!wr) r.data = (off == 16'h40) ? {30'b0, ref_en} : {30'b0, ti, ri};
      rsp_q.push_back(r);
      apb(wr, addr, data, 2);
    end else begin
      r.err = 1'b0;
      s.wr = wr; s.addr = off; s.wdata = data[7:0];
      if (wr) begin
        ref_mem[off[5:2]] = data[7:0];
        r.data = 32'h0;
      end else begin
        r.data = {24'b0, ref_mem[off[5:2]]};
      end
      rsp_q.push_back(r);
      stb_q.push_back(s);
      apb(wr, addr, data, 2);
    end
  endtask

  initial begin
    logic [31:0] rnd;
    logic [15:0] off;
    int k;
    int guard;
    for (int i = 0; i < 16; i++) begin
      rnd = $urandom;
      ref_mem[i] = rnd[7:0];
    end
    ref_mem[0] = 8'h34;
    ref_en = 2'b00;
    tb_load = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_prdata", prdata, 32'h0);
    check("rst_pready", {31'b0, pready}, 32'h0);
    check("rst_pslverr", {31'b0, pslverr}, 32'h0);
    check("rst_strobes", {29'b0, reg_cs_n, reg_wr_n, reg_rd_n}, 32'h7);
    check("rst_reg_addr", {16'b0, reg_addr}, 32'h0);
    check("rst_reg_wdata", {24'b0, reg_wdata}, 32'h0);
    check("rst_irq", {31'b0, irq}, 32'h0);
    tb_load = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;

    issue(1'b1, 32'h0000_000C, 32'h0000_005A);
    issue(1'b0, 32'h0000_0000, 32'h0);
    issue(1'b0, 32'h0000_0024, 32'h0);
    issue(1'b1, 32'h0000_0002, 32'h0000_00FF);

    issue(1'b1, 32'h0000_0040, 32'h0000_0001);
    ri = 1'b1; ti = 1'b0;
    check("irq_lag", {31'b0, irq}, 32'h0);
    @(negedge clk);
    check("irq_ri_set", {31'b0, irq}, 32'h1);
    ri = 1'b0;
    @(negedge clk);
    check("irq_ri_clear", {31'b0, irq}, 32'h0);
    ti = 1'b1;
    issue(1'b0, 32'h0000_0044, 32'h0);
    check("irq_ti_masked", {31'b0, irq}, 32'h0);
    ti = 1'b0;

    issue(1'b1, 32'h0000_000C, 32'h0000_0011);
    issue(1'b1, 32'h0000_000C, 32'h0000_0022);

    // Reset while a UART read strobe is on the wire
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 32'h0000_0004;
    @(posedge clk);
    #2;
    check("rd_strobe_before_reset", {31'b0, reg_rd_n}, 32'h0);
    reset_n = 1'b0;
    #1;
    check("reset_cs_n", {31'b0, reg_cs_n}, 32'h1);
    check("reset_rd_n", {31'b0, reg_rd_n}, 32'h1);
    check("reset_pready", {31'b0, pready}, 32'h0);
    psel = 1'b0; penable = 1'b0;
    ref_en = 2'b00;
    @(negedge clk);
    reset_n = 1'b1;
    issue(1'b0, 32'h0000_0040, 32'h0);
    issue(1'b0, 32'h0000_0004, 32'h0);

    for (int n = 0; n < 80; n++) begin
      rnd = $urandom;
      ri = rnd[0];
      ti = rnd[1];
      k = $urandom_range(0, 9);
      if (k < 5) off = 16'($urandom_range(0, 8) * 4);
      else if (k == 5) off = 16'h0040;
      else if (k == 6) off = 16'h0044;
      else if (k == 7) off = {rnd[15:2], 2'b00};
      else off = rnd[31:16];
      rnd = $urandom;
      issue(rnd[0], {rnd[31:16], off}, $urandom);
    end

    @(negedge clk);
    psel = 1'b0; penable = 1'b0;
    guard = 0;
    while (rsp_q.size() != 0 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    repeat (2) @(negedge clk);
    check("rsp_queue_drained", rsp_q.size(), 32'd0);
    check("strobe_queue_drained", stb_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_apb_bridge.md
# uart_apb_bridge

APB3 slave that adapts 32-bit system-bus transfers onto the UART block's 8-bit strobe register port (`reg_addr`/`reg_cs_n`/`reg_wr_n`/`reg_rd_n`/`reg_wdata`/`reg_rdata`). It sits directly upstream of the UART register interface, between the APB interconnect and the UART.

It also provides:
- address-error signalling;
- a fixed-latency read-capture sequence matched to the UART's registered read data;
- a one-cycle write strobe with a guaranteed idle gap, so each TRS write produces exactly one transmit trigger;
- maskable merging of `ri`/`ti` into a single registered `irq`.

## Interface
Parameters:
- `UART_LAST`, 16'h0020 — highest valid UART register offset (word-aligned).
- `IRQ_EN_ADDR`, 16'h0040 — bridge-local interrupt enable register, RW, bits[1:0] = {ti_en, ri_en}.
- `IRQ_STAT_ADDR`, 16'h0044 — bridge-local status, RO, bits[1:0] = {ti, ri}.

Ports:
- `clk` in 1 — clock.
- `reset_n` in 1 — reset, asynchronous, active-low.
- `psel` in 1 — APB select.
- `penable` in 1 — APB access phase.
- `pwrite` in 1 — 1 = write.
- `paddr` in 32 — address; only [15:0] decoded, [31:16] ignored.
- `pwdata` in 32 — write data; only [7:0] used.
- `prdata` out 32 — read data; {24'b0, byte}.
- `pready` out 1 — transfer complete.
- `pslverr` out 1 — address error, valid with `pready`.
- `reg_addr` out 16 — UART register offset.
- `reg_cs_n` out 1 — UART chip select, active-low.
- `reg_wr_n` out 1 — UART write strobe, active-low.
- `reg_rd_n` out 1 — UART read strobe, active-low.
- `reg_wdata` out 8 — UART write data.
- `reg_rdata` in 8 — UART read data; registered by the UART one cycle after the read strobe.
- `ri` in 1 — UART receive interrupt level.
- `ti` in 1 — UART transmit interrupt level.
- `irq` out 1 — merged interrupt, registered.

## Operation
- FSM states: IDLE, STROBE, CAPTURE, RESP. Encoding is free.
- IDLE:
  - On `psel & ~penable` (setup phase), latch `paddr[15:0]`, `pwrite`, `pwdata[7:0]` and the decode result.
  - Classify the access: ERR, LOCAL or UART.
  - ERR → RESP. UART or LOCAL → STROBE.
- Decode rules:
  - ERR if `paddr[1:0]` != 0.
  - ERR if the offset is above `UART_LAST` and is neither `IRQ_EN_ADDR` nor `IRQ_STAT_ADDR`.
  - LOCAL if the offset is `IRQ_EN_ADDR` or `IRQ_STAT_ADDR`.
  - UART for offsets 0x00–0x20.
- STROBE (exactly one cycle):
  - UART access: `reg_cs_n` = 0, plus `reg_wr_n` = 0 (write) or `reg_rd_n` = 0 (read).
  - LOCAL access: all strobes stay 1; a local write updates `irq_en` at the end of this cycle.
  - Always → CAPTURE.
- CAPTURE (one cycle):
  - All strobes are 1.
  - At the end of the cycle, the read byte is captured into the prdata register: `reg_rdata` for a UART read, `{6'b0, irq_en}` or `{6'b0, ti, ri}` for a local read.
  - Always → RESP.
- RESP:
  - `pready` = 1 and `pslverr` = `err_q`.
  - `prdata` holds the captured byte for reads and is 0 for writes and errors.
  - Always → IDLE. No abort: if `psel` drops early, the sequence still completes.
- `reg_addr`, `reg_wdata`: held from the latched values until the next setup phase.
- Writes to the read-only `IRQ_STAT_ADDR` are accepted and ignored, with no error.
- Writes to UART offsets are forwarded unconditionally; the UART ignores read-only fields.
- `irq <= |({ti, ri} & irq_en)` every cycle.

## Timing
- Reset values:
  - FSM = IDLE.
  - `reg_cs_n` = `reg_wr_n` = `reg_rd_n` = 1.
  - `reg_addr` = 0, `reg_wdata` = 0.
  - `prdata` = 0, `pready` = 0, `pslverr` = 0.
  - `irq_en` = 2'b00, `irq` = 0.
- Strobe outputs and `prdata` are registered. `pready`/`pslverr` are decoded from the state register; there is no combinational path from APB inputs.
- Cycle numbering for UART and LOCAL accesses: T0 = setup, T1 = STROBE (access phase starts, `pready` = 0), T2 = CAPTURE (UART `reg_rdata` valid), T3 = RESP (`pready` = 1). This gives 2 wait states.
- ERR access: T0 setup, T1 RESP with `pready` = `pslverr` = 1. No wait states and no strobe.
- Strobe isolation:
  - Strobes are never asserted for two consecutive cycles.
  - Back-to-back transfers yield at least 3 strobe-idle cycles between strobes: CAPTURE, RESP, next setup.
- `irq` lags `ri`/`ti`/`irq_en` changes by 1 cycle.
- Asynchronous reset mid-transfer: strobes deassert immediately, FSM returns to IDLE, the pending transfer is dropped with `pready` = 0, and `irq_en` clears.

## Test plan
- Write `paddr` = 0x0C, `pwdata` = 0x5A → `reg_cs_n`/`reg_wr_n` low for exactly one cycle at T1 with `reg_addr` = 0x000C, `reg_wdata` = 0x5A; `pready` at T3, `pslverr` = 0.
- Read `paddr` = 0x00 with `reg_rdata` = 0x34 driven from T2 → `reg_rd_n` low only at T1; `prdata` = 0x00000034 with `pready` at T3.
- Error cases:
  - Read `paddr` = 0x24 → `pready` = `pslverr` = 1 at T1, no strobe, `prdata` = 0.
  - Write `paddr` = 0x02 → `pready` = `pslverr` = 1 at T1, no strobe.
- Write 0x40 = 0x01, then hold `ri` = 1, `ti` = 0 → `irq` = 1 one cycle after the write completes. Then `ri` = 0 → `irq` = 0 next cycle. Read 0x44 with `ti` = 1 → `prdata` = 0x2.
- Two back-to-back TRS writes (0x0C: 0x11 then 0x22) → exactly two single-cycle strobe pulses separated by at least 3 idle cycles.
- Assert reset during STROBE of a read → `reg_cs_n` = `reg_rd_n` = 1 immediately, `pready` = 0. The next transfer after reset completes normally.
